// File: rtl/debug_tx_sequencer_if.sv
// -----------------------------------------------------------------------------
// debug_tx_sequencer_if
// Byte handshake between the debug dump sequencer and the UART transmitter.
//   tx_start : one-cycle pulse, transmitter loads tx_data
//   tx_data  : byte to transmit, held stable until tx_done
//   tx_done  : one-cycle pulse, transmitter finished the current byte
// master = sequencer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface debug_tx_sequencer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_done
  );
endinterface

// File: rtl/debug_tx_sequencer.sv
// -----------------------------------------------------------------------------
// debug_tx_sequencer
// On a dump trigger, snapshots the cycle count and PC, then walks the register
// file and serializes count, pc, reg[0..N_REGS-1] MSB byte first to the UART.
//
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-high reset
//   i_trigger    single-cycle dump request
//   i_count      cycle count (captured on trigger)
//   i_pc         program counter (captured on trigger)
//   o_reg_addr   register-file read address (0 outside register reads)
//   i_reg_data   register-file read data, valid 1 cycle after o_reg_addr
//   tx_if        UART byte handshake (master side)
//   o_busy       high from trigger acceptance until dump completion
//   o_done       one-cycle pulse after the last byte completes
//
// State  | Meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for trigger; snapshot taken on the accepting edge
// LOAD   | copy selected word into byte shift register
// SEND   | pulse tx_start with shift register MSB byte
// WAIT   | hold byte until tx_done; shift or advance to next word
// NEXT   | advance word index; set read address for register words
// RDREG  | register-file read latency cycle
// DONE   | pulse o_done, return to IDLE
// -----------------------------------------------------------------------------
module debug_tx_sequencer #(
  parameter int NB_DATA = 32,
  parameter int N_REGS  = 32,
  parameter int NB_ADDR = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_trigger,
  input  logic [NB_DATA-1:0]   i_count,
  input  logic [NB_DATA-1:0]   i_pc,
  output logic [NB_ADDR-1:0]   o_reg_addr,
  input  logic [NB_DATA-1:0]   i_reg_data,
  debug_tx_sequencer_if.master tx_if,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int NB_IDX   = $clog2(N_REGS + 3);

  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
  localparam logic [NB_IDX-1:0]  END_IDX   = NB_IDX'(N_REGS + 2);
  localparam logic [NB_IDX-1:0]  FIRST_REG = NB_IDX'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_NEXT,
    ST_RDREG,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [NB_DATA-1:0] r_count_snap;
  logic [NB_DATA-1:0] r_pc_snap;
  logic [NB_DATA-1:0] r_shift;
  logic [NB_BCNT-1:0] r_byte_cnt;
  logic [NB_IDX-1:0]  r_word_idx;
  logic [NB_ADDR-1:0] r_reg_addr;

  logic [NB_IDX-1:0]  w_idx_inc;
  logic [NB_IDX-1:0]  w_idx_reg;
  logic [NB_DATA-1:0] w_load_word;
  logic               w_last_byte;
  logic               w_tx_start;

  assign w_idx_inc   = r_word_idx + NB_IDX'(1);
  assign w_idx_reg   = w_idx_inc - FIRST_REG;
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);

  always_comb begin
    w_load_word = i_reg_data;
    if (r_word_idx == '0)
      w_load_word = r_count_snap;
    else if (r_word_idx == NB_IDX'(1))
      w_load_word = r_pc_snap;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_start   = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_trigger) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_SEND;
      ST_SEND: begin
        w_tx_start   = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_if.tx_done)
          w_state_next = w_last_byte ? ST_NEXT : ST_SEND;
      end
      ST_NEXT: begin
        if (w_idx_inc == END_IDX)
          w_state_next = ST_DONE;
        else if (w_idx_inc >= FIRST_REG)
          w_state_next = ST_RDREG;
        else
          w_state_next = ST_LOAD;
      end
      ST_RDREG: w_state_next = ST_LOAD;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count_snap <= '0;
      r_pc_snap    <= '0;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_word_idx   <= '0;
      r_reg_addr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_trigger) begin
            r_count_snap <= i_count;
            r_pc_snap    <= i_pc;
            r_word_idx   <= '0;
            r_reg_addr   <= '0;
          end
        end
        ST_LOAD: begin
          r_shift    <= w_load_word;
          r_byte_cnt <= '0;
          // address was held through RDREG and this cycle; release it now
          r_reg_addr <= '0;
        end
        ST_WAIT: begin
          if (tx_if.tx_done && !w_last_byte) begin
            r_shift    <= {r_shift[NB_DATA-9:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + NB_BCNT'(1);
          end
        end
        ST_NEXT: begin
          r_word_idx <= w_idx_inc;
          if (w_idx_inc != END_IDX && w_idx_inc >= FIRST_REG)
            r_reg_addr <= NB_ADDR'(w_idx_reg);
        end
        default: ;
      endcase
    end
  end

  assign tx_if.tx_start = w_tx_start;
  assign tx_if.tx_data  = r_shift[NB_DATA-1 -: 8];
  assign o_reg_addr     = r_reg_addr;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_debug_tx_sequencer
// Scoreboard bench: expected frames are pushed when a dump is triggered; a
// monitor acting as the UART transmitter pops and compares on every tx_start.
// -----------------------------------------------------------------------------
module tb_debug_tx_sequencer;
  localparam int NB_DATA = 32;
  localparam int N_REGS  = 32;
  localparam int NB_ADDR = 5;
  localparam int FRAME   = (2 + N_REGS) * NB_DATA / 8;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_trigger = 1'b0;
  logic [NB_DATA-1:0] i_count = '0;
  logic [NB_DATA-1:0] i_pc = '0;
  logic [NB_ADDR-1:0] o_reg_addr;
  logic [NB_DATA-1:0] r_reg_data = '0;
  logic               o_busy;
  logic               o_done;

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;

  debug_tx_sequencer_if u_if ();
  assign u_if.tx_done = resp_done | spur_done;

  always #5 i_clk = ~i_clk;

  debug_tx_sequencer #(
    .NB_DATA(NB_DATA), .N_REGS(N_REGS), .NB_ADDR(NB_ADDR)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_trigger  (i_trigger),
    .i_count    (i_count),
    .i_pc       (i_pc),
    .o_reg_addr (o_reg_addr),
    .i_reg_data (r_reg_data),
    .tx_if      (u_if),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  // register file model with one cycle read latency
  logic [NB_DATA-1:0] rf [N_REGS];
  always @(posedge i_clk) r_reg_data <= rf[o_reg_addr];

  // cycle count source: holds count_base, or free-runs when count_inc is set
  logic [NB_DATA-1:0] count_base = '0;
  logic               count_inc = 1'b0;
  always @(negedge i_clk) i_count = count_inc ? i_count + 1 : count_base;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int starts = 0, dones = 0, busy_rises = 0, busy_falls = 0;
  int tx_delay = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor + UART responder
  initial begin : monitor
    logic       pending;
    logic [7:0] held;
    int         cnt;
    logic       prev_busy;
    logic [7:0] exp_b;
    pending = 1'b0; held = '0; cnt = 0; prev_busy = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      resp_done = 1'b0;
      if (u_if.tx_start) begin
        starts++;
        check("queue_nonempty_on_start", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("tx_byte", 32'(u_if.tx_data), 32'(exp_b));
        end
        check("reg_addr_zero_in_send", 32'(o_reg_addr), 32'd0);
        pending = 1'b1;
        held    = u_if.tx_data;
        cnt     = tx_delay;
      end else if (pending && o_busy) begin
        check("tx_data_stable", 32'(u_if.tx_data), 32'(held));
        cnt--;
        if (cnt <= 0) begin
          resp_done = 1'b1;
          pending   = 1'b0;
        end
      end
      if (!o_busy) pending = 1'b0;
      if (o_done) begin
        dones++;
        check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
      end
      if (o_busy && !prev_busy) busy_rises++;
      if (!o_busy && prev_busy) busy_falls++;
      prev_busy = o_busy;
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic push_frame(input logic [31:0] c, input logic [31:0] p);
    logic [31:0] w;
    for (int i = 0; i < N_REGS + 2; i++) begin
      w = (i == 0) ? c : (i == 1) ? p : rf[i-2];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
  endtask

  task automatic pulse_trigger();
    i_trigger = 1'b1;
    tick();
    i_trigger = 1'b0;
  endtask

  task automatic wait_done(input int start_d, input int max_cycles);
    int n;
    n = 0;
    while (dones == start_d && n < max_cycles) begin
      tick();
      n++;
    end
    check("frame_done_within_budget", 32'(dones > start_d), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     32'(o_busy), 32'd0);
    check({tag, "_done"},     32'(o_done), 32'd0);
    check({tag, "_tx_start"}, 32'(u_if.tx_start), 32'd0);
    check({tag, "_tx_data"},  32'(u_if.tx_data), 32'd0);
    check({tag, "_reg_addr"}, 32'(o_reg_addr), 32'd0);
  endtask

  // full frame; lockout pulses a trigger at bytes 5 and 100; inc free-runs i_count
  task automatic run_frame(input logic [31:0] c, input logic [31:0] p,
                           input int delay, input bit lockout, input bit inc);
    int s0, d0, r0, f0, n;
    s0 = starts; d0 = dones; r0 = busy_rises; f0 = busy_falls;
    tx_delay   = delay;
    count_base = c;
    i_pc       = p;
    push_frame(c, p);
    pulse_trigger();
    count_inc = inc;
    if (lockout) begin
      n = 0;
      while (starts - s0 < 5 && n < 200) begin tick(); n++; end
      pulse_trigger();
      n = 0;
      while (starts - s0 < 100 && n < 2000) begin tick(); n++; end
      pulse_trigger();
    end
    wait_done(d0, (delay + 4) * (FRAME + 10) + 200);
    count_inc = 1'b0;
    tick(); tick();
    check("frame_start_count", 32'(starts - s0), 32'(FRAME));
    check("frame_done_count",  32'(dones - d0), 32'd1);
    check("frame_busy_rises",  32'(busy_rises - r0), 32'd1);
    check("frame_busy_falls",  32'(busy_falls - f0), 32'd1);
  endtask

  initial begin : stimulus
    int s0, d0, n;
    for (int k = 0; k < N_REGS; k++) rf[k] = k * 32'h0101_0101;

    // reset state
    i_reset = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    i_reset = 1'b0;
    repeat (2) tick();

    // basic dump
    run_frame(32'h0000_0010, 32'h0000_0040, 3, 1'b0, 1'b0);

    // snapshot immunity, different register contents
    for (int k = 0; k < N_REGS; k++) rf[k] = 32'hA500_0000 ^ (k * 32'h0001_0203);
    run_frame(32'h1234_5678, 32'hCAFE_F00D, 1, 1'b0, 1'b1);

    // busy lockout
    run_frame(32'hDEAD_BEEF, 32'h0000_1000, 2, 1'b1, 1'b0);

    // spurious tx_done in IDLE, then slow TX
    s0 = starts;
    for (int i = 0; i < 3; i++) begin
      spur_done = 1'b1; tick(); spur_done = 1'b0;
      repeat (4) tick();
      check("spurious_done_busy", 32'(o_busy), 32'd0);
    end
    check("spurious_done_no_start", 32'(starts - s0), 32'd0);
    run_frame(32'h0BAD_F00D, 32'h8000_0004, 200, 1'b0, 1'b0);

    // reset mid-dump after the 20th byte's start
    tx_delay = 3;
    count_base = 32'h5555_AAAA;
    i_pc = 32'h0000_0ABC;
    s0 = starts;
    push_frame(count_base, i_pc);
    pulse_trigger();
    n = 0;
    while (starts - s0 < 20 && n < 500) begin tick(); n++; end
    check("reached_20_starts", 32'(starts - s0), 32'd20);
    i_reset = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    exp_q.delete();
    s0 = starts;
    tick();
    i_reset = 1'b0;
    repeat (50) tick();
    check("no_start_after_reset", 32'(starts - s0), 32'd0);
    run_frame(32'h0000_0001, 32'h0000_0002, 2, 1'b0, 1'b0);

    // back-to-back: trigger on the o_done cycle and on the following cycle
    tx_delay   = 1;
    count_base = 32'h0102_0304;
    i_pc       = 32'h0506_0708;
    d0 = dones;
    push_frame(count_base, i_pc);
    pulse_trigger();
    n = 0;
    while (!o_done && n < 2000) begin tick(); n++; end
    check("b2b_first_done_seen", 32'(o_done), 32'd1);
    i_trigger = 1'b1;
    tick();
    check("b2b_busy_low_after_done", 32'(o_busy), 32'd0);
    count_base = 32'h1111_2222;
    i_pc       = 32'h3333_4444;
    s0 = starts;
    push_frame(count_base, i_pc);
    tick();
    i_trigger = 1'b0;
    check("b2b_busy_high_next", 32'(o_busy), 32'd1);
    d0 = dones;
    wait_done(d0, 2000);
    tick();
    check("b2b_second_frame_starts", 32'(starts - s0), 32'(FRAME));
    check("b2b_second_frame_done", 32'(dones - d0), 32'd1);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
